// File: rtl/lcg_pkg.sv
// Shared LCG constants and checker FSM state type, common to the generator and checker.
package lcg_pkg;

   localparam int unsigned LCG_A = 233;
   localparam int unsigned LCG_C = 197;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } lcg_state_t;

endpackage

// File: rtl/lcg_step.sv
// One LCG step f(x) = (A*x + C) mod 2^WIDTH; purely combinational, zero latency.
module lcg_step
   import lcg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned A     = LCG_A,
   parameter int unsigned C     = LCG_C
)(
   input  logic [WIDTH-1:0] i_x,
   output logic [WIDTH-1:0] o_y
);

   // Full double-width product, then keep the low WIDTH bits.
   assign o_y = WIDTH'((2*WIDTH)'(A) * {{WIDTH{1'b0}}, i_x} + (2*WIDTH)'(C));

endmodule

// File: rtl/lcg_checker.sv
// Self-synchronising LCG stream checker; outputs registered one cycle after the sample, no back-pressure.
// Define LCG_CHECKER_STATS_EN to implement the err_cnt/ok_cnt saturating counters (tied to 0 otherwise).
module lcg_checker
   import lcg_pkg::*;
#(
   parameter int unsigned A        = LCG_A,
   parameter int unsigned C        = LCG_C,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             err,
   output logic [15:0]      err_cnt,
   output logic [15:0]      ok_cnt
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   lcg_state_t       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_pred, w_pred_nxt;
   logic [WIDTH-1:0] w_f_in, w_f_pred;
   logic [MW-1:0]    r_match, w_match_nxt;
   logic [LW-1:0]    r_miss, w_miss_nxt;
   logic             w_hit, w_err_nxt;
   logic             r_err, r_locked;

   lcg_step #(.WIDTH(WIDTH), .A(A), .C(C)) u_step_in   (.i_x(in_data), .o_y(w_f_in));
   lcg_step #(.WIDTH(WIDTH), .A(A), .C(C)) u_step_pred (.i_x(r_pred),  .o_y(w_f_pred));

   assign w_hit = (in_data == r_pred);

   always_ff @(posedge clk) begin
      if (rst) r_state <= SEED;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pred_nxt  = r_pred;
      w_match_nxt = r_match;
      w_miss_nxt  = r_miss;
      w_err_nxt   = 1'b0;
      if (in_valid) begin
         case (r_state)
            SEED: begin
               w_pred_nxt  = w_f_in;
               w_match_nxt = '0;
               w_state_nxt = TRAIN;
            end
            TRAIN: begin
               // Matched or not, the received sample becomes the new seed.
               w_pred_nxt = w_f_in;
               if (w_hit) begin
                  w_match_nxt = r_match + MW'(1);
                  if (w_match_nxt == MW'(LOCK_CNT)) begin
                     w_state_nxt = LOCKED;
                     w_miss_nxt  = '0;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end
            LOCKED: begin
               if (w_hit) begin
                  w_pred_nxt = w_f_in;
                  w_miss_nxt = '0;
               end else begin
                  // Flywheel on the prediction so one bad byte costs one error.
                  w_err_nxt  = 1'b1;
                  w_pred_nxt = w_f_pred;
                  w_miss_nxt = r_miss + LW'(1);
                  if (w_miss_nxt == LW'(LOSS_CNT)) w_state_nxt = SEED;
               end
            end
            default: w_state_nxt = SEED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pred   <= '0;
         r_match  <= '0;
         r_miss   <= '0;
         r_err    <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_pred   <= w_pred_nxt;
         r_match  <= w_match_nxt;
         r_miss   <= w_miss_nxt;
         r_err    <= w_err_nxt;
         r_locked <= (w_state_nxt == LOCKED);
      end
   end

   assign locked = r_locked;
   assign err    = r_err;

`ifdef LCG_CHECKER_STATS_EN
   logic [15:0] r_err_cnt, r_ok_cnt;
   logic        w_ok_inc;

   assign w_ok_inc = in_valid && (r_state == LOCKED) && w_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
         r_ok_cnt  <= '0;
      end else begin
         if (w_err_nxt && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
         if (w_ok_inc  && (r_ok_cnt  != 16'hFFFF)) r_ok_cnt  <= r_ok_cnt  + 16'd1;
      end
   end

   assign err_cnt = r_err_cnt;
   assign ok_cnt  = r_ok_cnt;
`else
   assign err_cnt = '0;
   assign ok_cnt  = '0;
`endif

endmodule

// File: tb/tb_lcg_checker.sv
// Scoreboard bench for lcg_checker: a reference model pushes expected outputs per driven cycle.
module tb_lcg_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        locked, err;
   logic [15:0] err_cnt, ok_cnt;

   always #5 clk = ~clk;

   lcg_checker dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .locked(locked), .err(err), .err_cnt(err_cnt), .ok_cnt(ok_cnt)
   );

`ifdef LCG_CHECKER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        locked;
      logic        err;
      logic [15:0] err_cnt;
      logic [15:0] ok_cnt;
   } obs_t;

   obs_t sb[$];
   obs_t exp_o, got_o;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: 0=SEED, 1=TRAIN, 2=LOCKED
   int         m_state = 0;
   logic [7:0] m_pred  = 8'd0;
   int         m_match = 0, m_miss = 0, m_err_cnt = 0, m_ok_cnt = 0;
   logic       m_err   = 1'b0;

   logic [7:0] acq [5] = '{8'd0, 8'd197, 8'd18, 8'd39, 8'd68};

   function automatic logic [7:0] f(input logic [7:0] x);
      logic [15:0] p;
      p = 16'd233 * {8'd0, x} + 16'd197;
      return p[7:0];
   endfunction

   // Drive one cycle, advance the model, queue the expected post-edge outputs.
   task automatic step(input logic r, input logic v, input logic [7:0] d);
      obs_t e;
      rst = r; in_valid = v; in_data = d;
      if (r) begin
         m_state = 0; m_pred = 8'd0; m_match = 0; m_miss = 0;
         m_err_cnt = 0; m_ok_cnt = 0; m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         if (v) begin
            if (m_state == 0) begin
               m_pred = f(d); m_match = 0; m_state = 1;
            end else if (m_state == 1) begin
               if (d == m_pred) begin
                  m_match++;
                  if (m_match == 4) begin m_state = 2; m_miss = 0; end
               end else begin
                  m_match = 0;
               end
               m_pred = f(d);
            end else begin
               if (d == m_pred) begin
                  m_pred = f(d); m_miss = 0;
                  if (m_ok_cnt < 65535) m_ok_cnt++;
               end else begin
                  m_err = 1'b1; m_miss++;
                  if (m_err_cnt < 65535) m_err_cnt++;
                  m_pred = f(m_pred);
                  if (m_miss == 3) m_state = 0;
               end
            end
         end
      end
      e.locked  = (m_state == 2);
      e.err     = m_err;
      e.err_cnt = STATS ? 16'(m_err_cnt) : 16'd0;
      e.ok_cnt  = STATS ? 16'(m_ok_cnt)  : 16'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 8'd0);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL reset[%0d]: got %h want %h", i, got_o, exp_o);
         end
      end
      checks++;
      if ({locked, err, err_cnt, ok_cnt} !== 34'd0) begin
         errors++;
         $display("FAIL reset_zero: got %h want 0", {locked, err, err_cnt, ok_cnt});
      end
   endtask

   task automatic test_acquire(input string tag);
      int pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, acq[i]);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         pulses += int'(err);
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", tag, i, got_o, exp_o);
         end
      end
      checks++;
      if (locked !== 1'b1 || pulses != 0) begin
         errors++;
         $display("FAIL %s_lock: got locked=%b err_pulses=%0d want locked=1 err_pulses=0", tag, locked, pulses);
      end
   endtask

   task automatic test_single_corruption();
      logic [7:0] seq [3] = '{8'd169, 8'hFF, 8'd75};
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, seq[i]);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         pulses += int'(err);
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL corrupt[%0d]: got %h want %h", i, got_o, exp_o);
         end
      end
      checks++;
      if (locked !== 1'b1 || pulses != 1 || err_cnt !== (STATS ? 16'd1 : 16'd0)
          || ok_cnt !== (STATS ? 16'd2 : 16'd0)) begin
         errors++;
         $display("FAIL corrupt_sum: got locked=%b pulses=%0d err_cnt=%0d ok_cnt=%0d want 1/1/%0d/%0d",
                  locked, pulses, err_cnt, ok_cnt, STATS ? 1 : 0, STATS ? 2 : 0);
      end
   endtask

   task automatic test_loss();
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, m_pred ^ 8'hFF);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         pulses += int'(err);
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL loss[%0d]: got %h want %h", i, got_o, exp_o);
         end
      end
      checks++;
      if (locked !== 1'b0 || pulses != 3 || err_cnt !== (STATS ? 16'd4 : 16'd0)) begin
         errors++;
         $display("FAIL loss_sum: got locked=%b pulses=%0d err_cnt=%0d want 0/3/%0d",
                  locked, pulses, err_cnt, STATS ? 4 : 0);
      end
   endtask

   task automatic test_gaps();
      int pulses = 0;
      for (int i = 0; i < 5; i++) begin
         for (int g = 0; g < 6; g++) begin
            if (g == 0) step(1'b0, 1'b1, acq[i]);
            else        step(1'b0, 1'b0, 8'($urandom));
            exp_o = sb.pop_front();
            got_o = {locked, err, err_cnt, ok_cnt};
            pulses += int'(err);
            checks++;
            if (got_o !== exp_o) begin
               errors++;
               $display("FAIL gaps[%0d.%0d]: got %h want %h", i, g, got_o, exp_o);
            end
         end
      end
      checks++;
      if (locked !== 1'b1 || pulses != 0) begin
         errors++;
         $display("FAIL gaps_lock: got locked=%b err_pulses=%0d want 1/0", locked, pulses);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] part [3] = '{8'd0, 8'd197, 8'd18};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) step(1'b0, 1'b1, part[i]);
         else       step(1'b1, 1'b1, 8'd39);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL rst_train[%0d]: got %h want %h", i, got_o, exp_o);
         end
      end
      checks++;
      if ({locked, err, err_cnt, ok_cnt} !== 34'd0) begin
         errors++;
         $display("FAIL rst_train_zero: got %h want 0", {locked, err, err_cnt, ok_cnt});
      end
      test_acquire("relock_a");
      step(1'b0, 1'b1, 8'h00);
      void'(sb.pop_front());
      step(1'b1, 1'b1, 8'd169);
      exp_o = sb.pop_front();
      got_o = {locked, err, err_cnt, ok_cnt};
      checks++;
      if (got_o !== 34'd0 || exp_o !== 34'd0) begin
         errors++;
         $display("FAIL rst_locked_zero: got %h want 0", got_o);
      end
      test_acquire("relock_b");
   endtask

   task automatic test_back_to_back();
      logic       v;
      logic [7:0] d;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 11) == 0) ? 8'($urandom) : m_pred;
         step(1'b0, v, d);
         exp_o = sb.pop_front();
         got_o = {locked, err, err_cnt, ok_cnt};
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL b2b[%0d]: got %h want %h", i, got_o, exp_o);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
      test_reset();
      test_acquire("acquire");
      test_single_corruption();
      test_loss();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
